// File: rtl/td4_pkg.sv
// ---------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4-class 4-bit CPU datapath blocks.
//   TD4_WIDTH : native operand/result width of the TD4 configuration
//   operand_t : one operand-wide data word
// ---------------------------------------------------------------------------
package td4_pkg;

  localparam int TD4_WIDTH = 4;

  typedef logic [TD4_WIDTH-1:0] operand_t;

endpackage : td4_pkg

// File: rtl/td4_alu.sv
// ---------------------------------------------------------------------------
// td4_alu
// Adder ALU of the TD4-class CPU. It adds the selected source register to the
// instruction immediate. The sum goes back to the register file through the
// A/B/OUT/PC load path. The carry-out of each addition can be latched into
// the C flag, which the next instruction's JNC test reads.
//
// Ports
//   clk        in   1      system clock; the C flag samples on the rising edge
//   rst_n      in   1      asynchronous, active-low reset (clears the C flag only)
//   dat_in     in   WIDTH  source operand (A, B, IN or zero)
//   imdata     in   WIDTH  immediate field of the current instruction
//   carry_en   in   1      1 = load carry_flag into carry_q at the next rising clk
//   dat_out    out  WIDTH  dat_in + imdata, truncated to WIDTH bits
//   carry_flag out  1      carry-out of the current addition (combinational)
//   carry_q    out  1      registered carry flag (CPU C flag)
// ---------------------------------------------------------------------------
module td4_alu
  import td4_pkg::*;
#(
  parameter int WIDTH = TD4_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dat_in,
  input  logic [WIDTH-1:0] imdata,
  input  logic             carry_en,
  output logic [WIDTH-1:0] dat_out,
  output logic             carry_flag,
  output logic             carry_q
);

  logic carry_d;

  // Zero-extend both operands by one bit. The top bit of the sum is then the
  // carry-out, so wrap-around and the carry come from a single addition.
  assign {carry_flag, dat_out} = {1'b0, dat_in} + {1'b0, imdata};

  // The ternary keeps an unknown carry_en visible as X on the flag. An if/else
  // would quietly treat X as "hold".
  always_comb begin
    carry_d = carry_en ? carry_flag : carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule : td4_alu

// File: tb/tb_td4_alu.sv
// ---------------------------------------------------------------------------
// tb_td4_alu
// Self-checking bench for td4_alu. Expected sums and carries come from plain
// integer arithmetic on the operands. The expected C flag is a bench variable
// that follows the flag's load/hold/clear rules.
// ---------------------------------------------------------------------------
module tb_td4_alu;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] dat_in;
  logic [W-1:0] imdata;
  logic         carry_en;
  logic [W-1:0] dat_out;
  logic         carry_flag;
  logic         carry_q;

  int check_count = 0;
  int error_count = 0;
  int model_c     = 0;

  td4_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dat_in     (dat_in),
    .imdata     (imdata),
    .carry_en   (carry_en),
    .dat_out    (dat_out),
    .carry_flag (carry_flag),
    .carry_q    (carry_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input logic en);
    dat_in   = a[W-1:0];
    imdata   = b[W-1:0];
    carry_en = en;
  endtask

  // Compares the combinational outputs with ordinary integer addition.
  task automatic checkSum(input string tag, input int a, input int b);
    int sum;
    sum = a + b;
    checkOutput({tag, "_sum"}, 32'(dat_out), 32'(sum % 16));
    checkOutput({tag, "_cy"}, 32'(carry_flag), 32'(sum >= 16 ? 1 : 0));
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(1, 15, 1'b1);

    // First load a 1 into the flag, so that the reset check below can see it clear.
    repeat (2) @(posedge clk);
    #1 checkOutput("preload_cq", 32'(carry_q), 32'd1);

    // Reset asserted between edges must clear the flag with no clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_async_cq", 32'(carry_q), 32'd0);
    // The flag stays clear across edges while reset is held, even with a carry pending.
    repeat (2) @(posedge clk);
    #1 checkOutput("rst_hold_cq", 32'(carry_q), 32'd0);
    checkSum("rst_comb", 1, 15);

    // Directed combinational vectors, each checked 10 ns after the change.
    applyStimulus(1, 1, 1'b0);   #10 checkSum("d_1p1", 1, 1);
    applyStimulus(1, 14, 1'b0);  #10 checkSum("d_1p14", 1, 14);
    applyStimulus(1, 15, 1'b0);  #10 checkSum("d_1p15", 1, 15);
    applyStimulus(15, 15, 1'b0); #10 checkSum("d_15p15", 15, 15);

    // Exhaustive sweep over all 256 operand pairs.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(a, b, 1'b0);
        #10 checkSum($sformatf("sweep_%0d_%0d", a, b), a, b);
      end
    end

    // Flag register: the first capture comes on the first rise after release.
    @(negedge clk);
    applyStimulus(1, 15, 1'b1);
    rst_n = 1'b1;
    #1 checkOutput("release_cq", 32'(carry_q), 32'd0);
    @(posedge clk);
    #1 checkOutput("capture_cq", 32'(carry_q), 32'd1);
    @(negedge clk);
    applyStimulus(1, 1, 1'b0);
    @(posedge clk);
    #1 checkOutput("hold_cq", 32'(carry_q), 32'd1);
    @(negedge clk);
    applyStimulus(1, 1, 1'b1);
    @(posedge clk);
    #1 checkOutput("capture0_cq", 32'(carry_q), 32'd0);
    @(negedge clk);
    applyStimulus(8, 8, 1'b1);
    @(posedge clk);
    #1 checkOutput("capture1_cq", 32'(carry_q), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("midcyc_rst_cq", 32'(carry_q), 32'd0);
    checkSum("midcyc_rst_comb", 8, 8);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized cycles against the behavioural flag model, with occasional resets.
    model_c = 0;
    for (int i = 0; i < 300; i++) begin
      int a;
      int b;
      int en;
      @(negedge clk);
      a  = int'($urandom_range(0, 15));
      b  = int'($urandom_range(0, 15));
      en = int'($urandom_range(0, 1));
      applyStimulus(a, b, en[0]);
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        model_c = 0;
        #1 checkOutput($sformatf("rnd_rst_cq_%0d", i), 32'(carry_q), 32'd0);
        rst_n = 1'b1;
      end
      #1 checkSum($sformatf("rnd_%0d", i), a, b);
      @(posedge clk);
      if (en == 1) model_c = (a + b >= 16) ? 1 : 0;
      #1 checkOutput($sformatf("rnd_cq_%0d", i), 32'(carry_q), 32'(model_c));
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule : tb_td4_alu
